// File: rtl/traffic_light_controller_nway.sv
// N-approach demand-actuated traffic light controller with round-robin, demand-skipping service.
// Optional pedestrian WALK phase enabled by defining TLC_PED_EN (adds ped_req/walk ports).
module traffic_light_controller_nway #(
  parameter int N_WAY      = 4,
  parameter int GREEN_MIN  = 8,
  parameter int GREEN_MAX  = 32,
  parameter int YELLOW_CYC = 4,
  parameter int ALLRED_CYC = 2,
  parameter int WALK_CYC   = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_WAY-1:0]         sense,
  output logic [3*N_WAY-1:0]       lights,
  output logic [$clog2(N_WAY)-1:0] active
`ifdef TLC_PED_EN
  ,
  input  logic                     ped_req,
  output logic                     walk
`endif
);

  localparam int AW = $clog2(N_WAY);
  localparam int M1 = (GREEN_MAX > YELLOW_CYC) ? GREEN_MAX : YELLOW_CYC;
  localparam int M2 = (M1 > ALLRED_CYC) ? M1 : ALLRED_CYC;
  localparam int M3 = (M2 > WALK_CYC) ? M2 : WALK_CYC;
  localparam int TW = $clog2(M3 + 1);

`ifdef TLC_PED_EN
  typedef enum logic [1:0] {ST_ALLRED, ST_GREEN, ST_YELLOW, ST_WALK} state_t;
`else
  typedef enum logic [1:0] {ST_ALLRED, ST_GREEN, ST_YELLOW} state_t;
`endif

  state_t             r_state, w_state_next;
  logic [TW-1:0]      r_timer, w_timer_next;
  logic [AW-1:0]      r_active, w_active_next;
  logic [N_WAY-1:0]   r_pend, w_pend_next;
  logic [3*N_WAY-1:0] r_lights, w_lights_next;
  logic [AW-1:0]      w_sel;
  logic [AW:0]        w_sum  [N_WAY];
  logic [AW-1:0]      w_cand [N_WAY];
`ifdef TLC_PED_EN
  logic               r_ped_pend, w_ped_pend_next;
  logic               r_walk;
`endif

  // w_cand[k] is the approach (active + k + 1) mod N_WAY, i.e. search order after the owner.
  genvar gi;
  generate
    for (gi = 0; gi < N_WAY; gi++) begin : g_cand
      assign w_sum[gi]  = {1'b0, r_active} + (AW+1)'(gi + 1);
      assign w_cand[gi] = (w_sum[gi] >= (AW+1)'(N_WAY)) ?
                          AW'(w_sum[gi] - (AW+1)'(N_WAY)) : w_sum[gi][AW-1:0];
    end
  endgenerate

  // Nearest pending approach wins; with nothing pending, plain rotation (w_cand[0]).
  always_comb begin
    w_sel = w_cand[0];
    for (int k = N_WAY - 1; k >= 0; k--) begin
      if (r_pend[w_cand[k]]) w_sel = w_cand[k];
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_timer_next  = r_timer + TW'(1);
    w_active_next = r_active;
    w_pend_next   = r_pend | sense;
`ifdef TLC_PED_EN
    w_ped_pend_next = r_ped_pend | ped_req;
`endif
    case (r_state)
      ST_ALLRED: begin
        if (r_timer == TW'(ALLRED_CYC - 1)) begin
          w_timer_next = '0;
`ifdef TLC_PED_EN
          if (r_ped_pend) begin
            w_state_next    = ST_WALK;
            w_ped_pend_next = 1'b0;
          end else begin
`else
          begin
`endif
            w_state_next       = ST_GREEN;
            w_active_next      = w_sel;
            w_pend_next[w_sel] = 1'b0;
          end
        end
      end
      ST_GREEN: begin
        if ((r_timer == TW'(GREEN_MAX - 1)) ||
            ((r_timer >= TW'(GREEN_MIN - 1)) && !sense[r_active])) begin
          w_state_next = ST_YELLOW;
          w_timer_next = '0;
        end
      end
      ST_YELLOW: begin
        if (r_timer == TW'(YELLOW_CYC - 1)) begin
          w_state_next = ST_ALLRED;
          w_timer_next = '0;
        end
      end
`ifdef TLC_PED_EN
      ST_WALK: begin
        if (r_timer == TW'(WALK_CYC - 1)) begin
          w_state_next = ST_ALLRED;
          w_timer_next = '0;
        end
      end
`endif
      default: begin
        w_state_next = ST_ALLRED;
        w_timer_next = '0;
      end
    endcase
  end

  // Lights are decoded from the next state so the registered outputs track the state register.
  generate
    for (gi = 0; gi < N_WAY; gi++) begin : g_lights
      assign w_lights_next[3*gi +: 3] =
        (w_active_next != AW'(gi))  ? 3'b100 :
        (w_state_next == ST_GREEN)  ? 3'b001 :
        (w_state_next == ST_YELLOW) ? 3'b010 : 3'b100;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_ALLRED;
      r_timer  <= '0;
      r_active <= AW'(N_WAY - 1);
      r_pend   <= '0;
      r_lights <= {N_WAY{3'b100}};
`ifdef TLC_PED_EN
      r_ped_pend <= 1'b0;
      r_walk     <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_timer  <= w_timer_next;
      r_active <= w_active_next;
      r_pend   <= w_pend_next;
      r_lights <= w_lights_next;
`ifdef TLC_PED_EN
      r_ped_pend <= w_ped_pend_next;
      r_walk     <= (w_state_next == ST_WALK);
`endif
    end
  end

  assign lights = r_lights;
  assign active = r_active;
`ifdef TLC_PED_EN
  assign walk = r_walk;
`endif

endmodule

// File: tb/tb_traffic_light_controller_nway.sv
// Randomised bench for traffic_light_controller_nway: a 4-way and a 6-way instance checked
// cycle by cycle against a phase/countdown reference model built from the controller rules.
`timescale 1ns/1ps
module tb_traffic_light_controller_nway;
  localparam int MAXN = 6;
  localparam int YEL = 4, ARED = 2, WALKC = 6;
`ifdef TLC_PED_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif
  localparam int PH_RED = 0, PH_GO = 1, PH_CAUT = 2, PH_WALK = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  sense_a = '0;
  logic [5:0]  sense_b = '0;
  logic [11:0] lights_a;
  logic [17:0] lights_b;
  logic [1:0]  active_a;
  logic [2:0]  active_b;
  logic        ped_req = 1'b0;
  logic        walk_a, walk_b;

  always #5 clk = ~clk;

  traffic_light_controller_nway dut_a (
    .clk(clk), .rst(rst), .sense(sense_a), .lights(lights_a), .active(active_a)
`ifdef TLC_PED_EN
    , .ped_req(ped_req), .walk(walk_a)
`endif
  );

  traffic_light_controller_nway #(.N_WAY(6), .GREEN_MIN(3), .GREEN_MAX(5)) dut_b (
    .clk(clk), .rst(rst), .sense(sense_b), .lights(lights_b), .active(active_b)
`ifdef TLC_PED_EN
    , .ped_req(1'b0), .walk(walk_b)
`endif
  );

`ifndef TLC_PED_EN
  assign walk_a = 1'b0;
  assign walk_b = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: which phase, how long it has run, who owns it, who is waiting.
  int m_n, m_gmin, m_gmax, m_phase, m_cnt, m_owner;
  bit m_pend [MAXN];
  bit m_ped;
  bit use_b = 1'b0;

  task automatic m_reset(input int n, input int gmin, input int gmax);
    m_n = n; m_gmin = gmin; m_gmax = gmax;
    m_phase = PH_RED; m_cnt = 0; m_owner = n - 1; m_ped = 1'b0;
    for (int i = 0; i < MAXN; i++) m_pend[i] = 1'b0;
  endtask

  task automatic m_step(input logic [5:0] s, input logic pr);
    bit old_pend [MAXN];
    bit old_ped;
    bit found;
    int nxt;
    old_pend = m_pend;
    old_ped  = m_ped;
    for (int i = 0; i < m_n; i++) if (s[i]) m_pend[i] = 1'b1;
    if (PED && pr) m_ped = 1'b1;
    case (m_phase)
      PH_RED: begin
        if (m_cnt == ARED - 1) begin
          m_cnt = 0;
          if (PED && old_ped) begin
            m_phase = PH_WALK;
            m_ped   = 1'b0;
          end else begin
            found = 1'b0;
            nxt   = (m_owner + 1) % m_n;
            for (int k = 1; k <= m_n; k++) begin
              if (!found && old_pend[(m_owner + k) % m_n]) begin
                found = 1'b1;
                nxt   = (m_owner + k) % m_n;
              end
            end
            m_owner = nxt;
            m_pend[nxt] = 1'b0;
            m_phase = PH_GO;
          end
        end else m_cnt++;
      end
      PH_GO: begin
        if (m_cnt == m_gmax - 1 || (m_cnt >= m_gmin - 1 && !s[m_owner])) begin
          m_phase = PH_CAUT; m_cnt = 0;
        end else m_cnt++;
      end
      PH_CAUT: begin
        if (m_cnt == YEL - 1) begin m_phase = PH_RED; m_cnt = 0; end else m_cnt++;
      end
      default: begin
        if (m_cnt == WALKC - 1) begin m_phase = PH_RED; m_cnt = 0; end else m_cnt++;
      end
    endcase
  endtask

  function automatic logic [17:0] m_lights();
    logic [17:0] l = '0;
    for (int i = 0; i < m_n; i++) begin
      if (i == m_owner && m_phase == PH_GO)        l[3*i +: 3] = 3'b001;
      else if (i == m_owner && m_phase == PH_CAUT) l[3*i +: 3] = 3'b010;
      else                                         l[3*i +: 3] = 3'b100;
    end
    return l;
  endfunction

  function automatic logic [17:0] obs_lights();
    return use_b ? lights_b : {6'b0, lights_a};
  endfunction
  function automatic int obs_active();
    return use_b ? int'(active_b) : int'(active_a);
  endfunction
  function automatic logic obs_walk();
    return use_b ? walk_b : walk_a;
  endfunction
  function automatic int obs_green();
    logic [17:0] l = obs_lights();
    int r = -1;
    for (int i = 0; i < m_n; i++) if (l[3*i +: 3] == 3'b001) r = i;
    return r;
  endfunction
  function automatic int obs_nonred();
    logic [17:0] l = obs_lights();
    int c = 0;
    for (int i = 0; i < m_n; i++) if (l[3*i +: 3] != 3'b100) c++;
    return c;
  endfunction

  // One clock: drive inputs now, advance the model at the edge, return 1ns after it.
  task automatic cycle(input logic [5:0] s, input logic pr);
    if (use_b) begin sense_b = s; sense_a = '0; end
    else begin sense_a = s[3:0]; sense_b = '0; end
    ped_req = pr;
    @(posedge clk);
    m_step(s, pr);
    #1;
  endtask

  task automatic do_reset(input bit b, input int n, input int gmin, input int gmax);
    @(negedge clk);
    rst = 1'b1; sense_a = '0; sense_b = '0; ped_req = 1'b0; use_b = b;
    m_reset(n, gmin, gmax);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    use_b = 1'b0;
    m_reset(4, 8, 32);
    rst = 1'b1;
    sense_a = 4'($urandom);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (lights_a !== 12'h924 || active_a !== 2'd3 || walk_a !== 1'b0)
      begin errors++; $display("FAIL reset_a lights=%h active=%0d walk=%b want 924/3/0", lights_a, active_a, walk_a); end
    checks++;
    if (lights_b !== 18'h24924 || active_b !== 3'd5)
      begin errors++; $display("FAIL reset_b lights=%h active=%0d want 24924/5", lights_b, active_b); end
    @(negedge clk);
    rst = 1'b0; sense_a = '0;
    n = 0;
    while (n < 10 && obs_green() != 0) begin
      cycle(6'd0, 1'b0);
      n++;
      checks++;
      if (obs_lights() !== m_lights() || obs_active() != m_owner)
        begin errors++; $display("FAIL reset_release n=%0d lights=%h want %h active=%0d want %0d", n, obs_lights(), m_lights(), obs_active(), m_owner); end
    end
    checks++;
    if (n != ARED) begin errors++; $display("FAIL first_green_latency got %0d want %0d", n, ARED); end
  endtask

  task automatic test_fixed_rotation(input bit b, input int n, input int gmin, input int gmax,
                                     input int want_phases);
    int owners[$];
    int prev, cur, glen;
    do_reset(b, n, gmin, gmax);
    prev = -1; glen = 0;
    for (int c = 0; c < 200 && owners.size() < want_phases; c++) begin
      cycle(6'd0, 1'b0);
      checks++;
      if (obs_lights() !== m_lights() || obs_active() != m_owner || obs_nonred() > 1)
        begin errors++; $display("FAIL rotation n=%0d c=%0d lights=%h want %h active=%0d want %0d", n, c, obs_lights(), m_lights(), obs_active(), m_owner); end
      cur = obs_green();
      if (cur >= 0) begin
        if (prev < 0) owners.push_back(cur);
        glen++;
      end else if (prev >= 0) begin
        checks++;
        if (glen != gmin) begin errors++; $display("FAIL fixed_green_len n=%0d got %0d want %0d", n, glen, gmin); end
        glen = 0;
      end
      prev = cur;
    end
    checks++;
    if (owners.size() != want_phases)
      begin errors++; $display("FAIL rotation_count n=%0d got %0d want %0d", n, owners.size(), want_phases); end
    for (int i = 0; i < owners.size(); i++) begin
      checks++;
      if (owners[i] != i % n) begin errors++; $display("FAIL rotation_order n=%0d idx=%0d got %0d want %0d", n, i, owners[i], i % n); end
    end
  endtask

  task automatic test_extension(input int drop_at, input int want_len);
    int glen;
    bit seen_yellow;
    do_reset(1'b0, 4, 8, 32);
    for (int c = 0; c < 10 && obs_green() != 0; c++) cycle(6'd0, 1'b0);
    glen = 1;
    seen_yellow = 1'b0;
    for (int i = 0; i < 40 && !seen_yellow; i++) begin
      cycle({2'b0, 3'($urandom), (drop_at < 0 || i < drop_at) ? 1'b1 : 1'b0}, 1'b0);
      checks++;
      if (obs_lights() !== m_lights() || obs_active() != m_owner)
        begin errors++; $display("FAIL extension i=%0d lights=%h want %h", i, obs_lights(), m_lights()); end
      if (lights_a[2:0] == 3'b001) glen++;
      else seen_yellow = 1'b1;
    end
    checks++;
    if (lights_a[2:0] !== 3'b010) begin errors++; $display("FAIL extension_yellow got %b want 010", lights_a[2:0]); end
    checks++;
    if (glen != want_len) begin errors++; $display("FAIL extension_len drop=%0d got %0d want %0d", drop_at, glen, want_len); end
  endtask

  task automatic test_skip();
    int p, cur, prev, cnt;
    int owners[$];
    do_reset(1'b0, 4, 8, 32);
    for (int c = 0; c < 10 && obs_green() != 0; c++) cycle(6'd0, 1'b0);
    p = $urandom_range(0, 6);
    prev = 0; cnt = 0;
    for (int i = 0; i < 60 && owners.size() < 2; i++) begin
      cycle((i == p) ? 6'b000100 : 6'd0, 1'b0);
      checks++;
      if (obs_lights() !== m_lights() || obs_active() != m_owner)
        begin errors++; $display("FAIL skip i=%0d lights=%h want %h active=%0d want %0d", i, obs_lights(), m_lights(), obs_active(), m_owner); end
      cur = obs_green();
      if (cur >= 0 && prev < 0) owners.push_back(cur);
      prev = cur;
    end
    checks++;
    if (owners.size() != 2 || owners[0] != 2 || owners[1] != 3)
      begin errors++; $display("FAIL skip_order got %0d:%0d want 2:3 (found %0d)", owners.size() > 0 ? owners[0] : -1, owners.size() > 1 ? owners[1] : -1, owners.size()); end
  endtask

  task automatic test_reset_mid_yellow();
    int n;
    do_reset(1'b0, 4, 8, 32);
    for (int c = 0; c < 30 && lights_a[2:0] != 3'b010; c++) cycle(6'd0, 1'b0);
    cycle(6'd0, 1'b0);
    checks++;
    if (lights_a[2:0] !== 3'b010) begin errors++; $display("FAIL second_yellow got %b want 010", lights_a[2:0]); end
    rst = 1'b1;
    m_reset(4, 8, 32);
    #2;
    checks++;
    if (lights_a !== 12'h924 || active_a !== 2'd3)
      begin errors++; $display("FAIL async_reset lights=%h active=%0d want 924/3", lights_a, active_a); end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (n < 10 && obs_green() < 0) begin cycle(6'd0, 1'b0); n++; end
    checks++;
    if (obs_green() != 0 || n != ARED)
      begin errors++; $display("FAIL restart_green owner=%0d after %0d want 0 after %0d", obs_green(), n, ARED); end
  endtask

`ifdef TLC_PED_EN
  task automatic test_ped();
    int wcount, after, prev, cur;
    do_reset(1'b0, 4, 8, 32);
    for (int c = 0; c < 40 && lights_a[5:3] != 3'b001; c++) cycle(6'd0, 1'b0);
    cycle(6'd0, 1'b1);
    wcount = 0; after = -1; prev = 1;
    for (int i = 0; i < 40 && after < 0; i++) begin
      cycle(6'd0, 1'b0);
      checks++;
      if (obs_lights() !== m_lights() || obs_walk() !== (m_phase == PH_WALK) || (walk_a && obs_nonred() != 0))
        begin errors++; $display("FAIL ped i=%0d lights=%h want %h walk=%b want %b", i, obs_lights(), m_lights(), obs_walk(), m_phase == PH_WALK); end
      if (walk_a) wcount++;
      cur = obs_green();
      if (cur >= 0 && prev < 0) after = cur;
      prev = cur;
    end
    checks++;
    if (wcount != WALKC || after != 2)
      begin errors++; $display("FAIL ped_walk walk_cycles=%0d next_green=%0d want %0d/2", wcount, after, WALKC); end
  endtask
`endif

  task automatic test_cap6();
    int glen, prev, cur;
    do_reset(1'b1, 6, 3, 5);
    glen = 0; prev = -1;
    for (int c = 0; c < 60; c++) begin
      cycle(6'b111111, 1'b0);
      checks++;
      if (obs_lights() !== m_lights() || obs_active() != m_owner)
        begin errors++; $display("FAIL cap6 c=%0d lights=%h want %h", c, obs_lights(), m_lights()); end
      cur = obs_green();
      if (cur >= 0) glen++;
      else if (prev >= 0) begin
        checks++;
        if (glen != 5) begin errors++; $display("FAIL cap6_len got %0d want 5", glen); end
        glen = 0;
      end
      prev = cur;
    end
  endtask

  task automatic test_random();
    logic pr;
    do_reset(1'b0, 4, 8, 32);
    for (int c = 0; c < 400; c++) begin
      pr = PED && ($urandom_range(0, 40) == 0);
      cycle({2'b0, 4'($urandom & $urandom)}, pr);
      checks++;
      if (obs_lights() !== m_lights() || obs_active() != m_owner || obs_walk() !== (m_phase == PH_WALK))
        begin errors++; $display("FAIL random c=%0d lights=%h want %h active=%0d want %0d", c, obs_lights(), m_lights(), obs_active(), m_owner); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fixed_rotation(1'b0, 4, 8, 32, 5);
    test_extension(-1, 32);
    test_extension(12, 13);
    test_skip();
    test_reset_mid_yellow();
`ifdef TLC_PED_EN
    test_ped();
`endif
    test_fixed_rotation(1'b1, 6, 3, 5, 7);
    test_cap6();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_light_controller_nway.md
# traffic_light_controller_nway

- Parametrised N-approach traffic light controller: one approach non-red at a time.
- Demand-actuated green with minimum/maximum limits, fixed yellow, all-red clearance between phases.
- Round-robin service that skips approaches with no pending demand, falling back to plain rotation when nothing is pending.
- Drop-in next generation of the fixed 4-way controller; lights use the same one-hot {RED,YELLOW,GREEN} encoding the existing bench decodes.

## Interface
- N_WAY, 4, number of approaches (>= 2)
- GREEN_MIN, 8, minimum green duration in cycles (>= 1)
- GREEN_MAX, 32, maximum green duration in cycles (>= GREEN_MIN)
- YELLOW_CYC, 4, yellow duration in cycles (>= 1)
- ALLRED_CYC, 2, all-red clearance duration in cycles (>= 1)
- WALK_CYC, 6, pedestrian walk duration in cycles (used only with TLC_PED_EN)
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- sense  input  N_WAY  per-approach vehicle detector, level, synchronous to clk
- lights  output  3*N_WAY  approach i at [3i+2:3i]; 100 RED, 010 YELLOW, 001 GREEN
- active  output  $clog2(N_WAY)  index of approach currently owning (or last owning) the phase
- ped_req  input  1  pedestrian request pulse/level (TLC_PED_EN only)
- walk  output  1  pedestrian WALK indication (TLC_PED_EN only)

## Operation
- States: ALLRED, GREEN, YELLOW, WALK (WALK only with TLC_PED_EN). All outputs registered.
- Reset values: state ALLRED, timer 0, all lights 100, active = N_WAY-1, pend = 0, walk = 0.
- pend[i] set on any cycle sense[i]=1; cleared on the edge approach i enters GREEN (clear wins over set for that approach).
- ALLRED: all lights 100, for ALLRED_CYC cycles. At its last cycle, select next: first i with pend[i]=1 searching active+1, active+2, … wrapping mod N_WAY (active itself searched last). If no pend, next = (active+1) mod N_WAY. Then GREEN, active = next.
- GREEN: lights[active] = 001, others 100. Green count g starts at 0. Terminate at end of cycle where g = GREEN_MAX-1, or g >= GREEN_MIN-1 and sense[active]=0. Then YELLOW.
- YELLOW: lights[active] = 010 for YELLOW_CYC cycles, then ALLRED.
- Timer width $clog2(max(GREEN_MAX, YELLOW_CYC, ALLRED_CYC, WALK_CYC)+1); counter never wraps.
- Invariant: at most one lights field non-100 in any cycle; never GREEN→RED without YELLOW.

## Timing
- From first rising edge with rst=0: ALLRED_CYC cycles red, then first green (approach 0 with no demand).
- Fixed-time cycle per approach (sense=0): GREEN_MIN + YELLOW_CYC + ALLRED_CYC cycles; defaults 14.
- sense change affects termination decision on the same edge it is sampled (no extra latency).
- rst asserted mid-operation: lights go all 100, walk 0 immediately (asynchronous), pend cleared; restart as from reset.

## Configuration
- TLC_PED_EN defined: ped_req/walk ports present; ped_pend set by ped_req, cleared on WALK entry. At end of ALLRED, if ped_pend=1, enter WALK (all 100, walk=1) for WALK_CYC cycles, then ALLRED again, then normal selection. ped_pend wins over vehicle selection.
- TLC_PED_EN undefined: ports, WALK state and WALK_CYC logic absent; ALLRED always proceeds to GREEN.

## Test plan
- Defaults, sense=0: all 100 during rst; after release 2 red cycles, then greens 0,1,2,3,0 each 8 cycles + 4 yellow + 2 all-red; never two non-red fields.
- Extension: sense[0] held 1 → approach 0 green exactly 32 cycles, then 4 yellow; sense[0] dropped at g=12 → yellow starts after 13 green cycles.
- Skip: during approach 0 green pulse sense[2] one cycle only → next green is 2 (1 skipped), pend[2] cleared on entry.
- Ped (TLC_PED_EN): pulse ped_req during approach 1 green → after yellow and 2 all-red, walk=1 for 6 cycles with all 100, 2 all-red, then next approach green; walk never 1 while any light non-100.
- Reset mid-yellow: assert rst on 2nd yellow cycle → lights all 100 before next edge, active = N_WAY-1; after release first green is approach 0.
- N_WAY=6, GREEN_MIN=3, GREEN_MAX=5: rotation 0..5 wraps to 0; held sense caps green at 5 cycles.
